// File: rtl/load_store_unit_pkg.sv
// rtl/load_store_unit_pkg.sv - shared size codes, fault codes, FSM states and load extension helper
package load_store_unit_pkg;

    localparam logic [2:0] SZ_B  = 3'd0;
    localparam logic [2:0] SZ_H  = 3'd1;
    localparam logic [2:0] SZ_W  = 3'd2;
    localparam logic [2:0] SZ_BU = 3'd4;
    localparam logic [2:0] SZ_HU = 3'd5;

    typedef enum logic [1:0] {
        FLT_NONE  = 2'b00,
        FLT_MISAL = 2'b01,
        FLT_ILLSZ = 2'b10,
        FLT_RANGE = 2'b11
    } fault_e;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_e;

    // Memory returns the addressed sub-word right-justified; widen it to 32 bits per size code.
    function automatic logic [31:0] load_extend(input logic [31:0] raw, input logic [2:0] size);
        logic [31:0] res;
        case (size)
            SZ_B:    res = {{24{raw[7]}}, raw[7:0]};
            SZ_H:    res = {{16{raw[15]}}, raw[15:0]};
            SZ_BU:   res = {24'd0, raw[7:0]};
            SZ_HU:   res = {16'd0, raw[15:0]};
            default: res = raw;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/lsu_check.sv
// rtl/lsu_check.sv - combinational size/range/alignment decode to a fault code
module lsu_check
    import load_store_unit_pkg::*;
#(
    parameter int unsigned MEM_BYTES = 256
) (
    input  logic        we,
    input  logic [2:0]  size,
    input  logic [31:0] addr,
    output fault_e      fault
);

    logic illegal;
    logic out_of_range;
    logic misaligned;

    // Illegal size outranks range, range outranks alignment.
    always_comb begin
        illegal      = 1'b0;
        out_of_range = 1'b0;
        misaligned   = 1'b0;
        fault        = FLT_NONE;

        case (size)
            SZ_B, SZ_H, SZ_W: illegal = 1'b0;
            SZ_BU, SZ_HU:     illegal = we;      // unsigned variants only exist for loads
            default:          illegal = 1'b1;
        endcase

        out_of_range = (addr >= MEM_BYTES);

        // Halfwords may straddle within a word; only offset 3 crosses the word boundary.
        misaligned = (((size == SZ_H) || (size == SZ_HU)) && (addr[1:0] == 2'b11))
                   || ((size == SZ_W) && (addr[1:0] != 2'b00));

        if (illegal)
            fault = FLT_ILLSZ;
        else if (out_of_range)
            fault = FLT_RANGE;
        else if (misaligned)
            fault = FLT_MISAL;
    end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - core-side load/store front end to the data memory
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int unsigned MEM_LAT   = 1,
    parameter int unsigned MEM_BYTES = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        core_req_i,
    input  logic        core_we_i,
    input  logic [2:0]  core_size_i,
    input  logic [31:0] core_addr_i,
    input  logic [31:0] core_wd_i,
    output logic        core_stall_o,
    output logic [31:0] core_rd_o,
    output logic [1:0]  core_fault_o,
    output logic        mem_we_o,
    output logic [2:0]  mem_size_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wd_o,
    input  logic [31:0] mem_rd_i,
    output logic [15:0] ld_cnt_o,
    output logic [15:0] st_cnt_o
);

    localparam logic [1:0] LAT_LOAD = 2'(MEM_LAT);

    state_e      state_q, state_d;
    logic [1:0]  lat_cnt_q, lat_cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [2:0]  size_q, size_d;
    logic [31:0] rdata_q, rdata_d;
    logic [15:0] ld_cnt_q, st_cnt_q;
    logic        ld_inc, st_inc;
    fault_e      chk_fault;
    logic [31:0] ld_ext;

    lsu_check #(
        .MEM_BYTES (MEM_BYTES)
    ) u_check (
        .we    (core_we_i),
        .size  (core_size_i),
        .addr  (core_addr_i),
        .fault (chk_fault)
    );

    assign ld_ext   = load_extend(mem_rd_i, size_q);
    assign ld_cnt_o = ld_cnt_q;
    assign st_cnt_o = st_cnt_q;

    // State, latched load context and saturating op counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            lat_cnt_q <= 2'd0;
            addr_q    <= 32'd0;
            size_q    <= 3'd0;
            rdata_q   <= 32'd0;
            ld_cnt_q  <= 16'd0;
            st_cnt_q  <= 16'd0;
        end else begin
            state_q   <= state_d;
            lat_cnt_q <= lat_cnt_d;
            addr_q    <= addr_d;
            size_q    <= size_d;
            rdata_q   <= rdata_d;
            if (ld_inc && (ld_cnt_q != 16'hFFFF))
                ld_cnt_q <= ld_cnt_q + 16'd1;
            if (st_inc && (st_cnt_q != 16'hFFFF))
                st_cnt_q <= st_cnt_q + 16'd1;
        end
    end

    // Next-state and memory/core port drive; memory port is quiet unless an access is legal.
    always_comb begin
        state_d      = state_q;
        lat_cnt_d    = lat_cnt_q;
        addr_d       = addr_q;
        size_d       = size_q;
        rdata_d      = rdata_q;
        ld_inc       = 1'b0;
        st_inc       = 1'b0;
        core_stall_o = 1'b0;
        core_rd_o    = rdata_q;
        core_fault_o = FLT_NONE;
        mem_we_o     = 1'b0;
        mem_size_o   = 3'd0;
        mem_addr_o   = 32'd0;
        mem_wd_o     = 32'd0;

        case (state_q)
            IDLE: begin
                if (core_req_i) begin
                    if (chk_fault != FLT_NONE) begin
                        core_fault_o = chk_fault;
                    end else if (core_we_i) begin
                        mem_we_o   = 1'b1;
                        mem_size_o = core_size_i;
                        mem_addr_o = core_addr_i;
                        mem_wd_o   = core_wd_i;
                        st_inc     = 1'b1;
                    end else begin
                        mem_size_o   = core_size_i;
                        mem_addr_o   = core_addr_i;
                        core_stall_o = 1'b1;
                        addr_d       = core_addr_i;
                        size_d       = core_size_i;
                        lat_cnt_d    = LAT_LOAD;
                        state_d      = WAIT;
                    end
                end
            end
            WAIT: begin
                // Request inputs are ignored here: the core holds the load until stall drops.
                mem_size_o = size_q;
                mem_addr_o = addr_q;
                lat_cnt_d  = lat_cnt_q - 2'd1;
                if (lat_cnt_q > 2'd1) begin
                    core_stall_o = 1'b1;
                end else begin
                    core_rd_o = ld_ext;
                    rdata_d   = ld_ext;
                    ld_inc    = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed self-checking bench for load_store_unit at MEM_LAT 1 and 3
module tb_load_store_unit;
    import load_store_unit_pkg::*;

    logic clk = 1'b0;
    logic rst_n;

    logic        req  [2];
    logic        we   [2];
    logic [2:0]  size [2];
    logic [31:0] addr [2];
    logic [31:0] wd   [2];

    logic        stall0, stall1, mwe0, mwe1;
    logic [31:0] rd0, rd1, madr0, madr1, mwd0, mwd1, mrd0, mrd1;
    logic [1:0]  flt0, flt1;
    logic [2:0]  msz0, msz1;
    logic [15:0] ldc0, ldc1, stc0, stc1;

    logic [7:0]  mem0 [256];
    logic [7:0]  mem1 [256];
    logic [31:0] p0, p1a, p1b, p1c;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    load_store_unit #(.MEM_LAT(1), .MEM_BYTES(256)) u_dut_lat1 (
        .clk(clk), .rst_n(rst_n),
        .core_req_i(req[0]), .core_we_i(we[0]), .core_size_i(size[0]),
        .core_addr_i(addr[0]), .core_wd_i(wd[0]),
        .core_stall_o(stall0), .core_rd_o(rd0), .core_fault_o(flt0),
        .mem_we_o(mwe0), .mem_size_o(msz0), .mem_addr_o(madr0), .mem_wd_o(mwd0),
        .mem_rd_i(mrd0), .ld_cnt_o(ldc0), .st_cnt_o(stc0)
    );

    load_store_unit #(.MEM_LAT(3), .MEM_BYTES(256)) u_dut_lat3 (
        .clk(clk), .rst_n(rst_n),
        .core_req_i(req[1]), .core_we_i(we[1]), .core_size_i(size[1]),
        .core_addr_i(addr[1]), .core_wd_i(wd[1]),
        .core_stall_o(stall1), .core_rd_o(rd1), .core_fault_o(flt1),
        .mem_we_o(mwe1), .mem_size_o(msz1), .mem_addr_o(madr1), .mem_wd_o(mwd1),
        .mem_rd_i(mrd1), .ld_cnt_o(ldc1), .st_cnt_o(stc1)
    );

    function automatic logic [31:0] rdfmt(input logic [7:0] b0, b1, b2, b3, input logic [2:0] sz);
        case (sz)
            3'd0, 3'd4: return {24'd0, b0};
            3'd1, 3'd5: return {16'd0, b1, b0};
            default:    return {b3, b2, b1, b0};
        endcase
    endfunction

    // Little-endian byte memory behind the MEM_LAT=1 unit.
    always @(posedge clk) begin
        if (mwe0) begin
            mem0[madr0[7:0]] <= mwd0[7:0];
            if (msz0 != 3'd0) mem0[madr0[7:0] + 8'd1] <= mwd0[15:8];
            if (msz0 == 3'd2) begin
                mem0[madr0[7:0] + 8'd2] <= mwd0[23:16];
                mem0[madr0[7:0] + 8'd3] <= mwd0[31:24];
            end
        end
        p0 <= rdfmt(mem0[madr0[7:0]], mem0[madr0[7:0] + 8'd1],
                    mem0[madr0[7:0] + 8'd2], mem0[madr0[7:0] + 8'd3], msz0);
    end
    assign mrd0 = p0;

    // Same memory behind the MEM_LAT=3 unit with a three-stage read pipe.
    always @(posedge clk) begin
        if (mwe1) begin
            mem1[madr1[7:0]] <= mwd1[7:0];
            if (msz1 != 3'd0) mem1[madr1[7:0] + 8'd1] <= mwd1[15:8];
            if (msz1 == 3'd2) begin
                mem1[madr1[7:0] + 8'd2] <= mwd1[23:16];
                mem1[madr1[7:0] + 8'd3] <= mwd1[31:24];
            end
        end
        p1a <= rdfmt(mem1[madr1[7:0]], mem1[madr1[7:0] + 8'd1],
                     mem1[madr1[7:0] + 8'd2], mem1[madr1[7:0] + 8'd3], msz1);
        p1b <= p1a;
        p1c <= p1b;
    end
    assign mrd1 = p1c;

    function automatic logic [31:0] o_stall(input int k); return 32'(k == 0 ? stall0 : stall1); endfunction
    function automatic logic [31:0] o_rd(input int k);    return k == 0 ? rd0 : rd1;               endfunction
    function automatic logic [31:0] o_flt(input int k);   return 32'(k == 0 ? flt0 : flt1);     endfunction
    function automatic logic [31:0] o_mwe(input int k);   return 32'(k == 0 ? mwe0 : mwe1);     endfunction
    function automatic logic [31:0] o_madr(input int k);  return k == 0 ? madr0 : madr1;           endfunction
    function automatic logic [31:0] o_mwd(input int k);   return k == 0 ? mwd0 : mwd1;             endfunction
    function automatic logic [31:0] o_ldc(input int k);   return 32'(k == 0 ? ldc0 : ldc1);     endfunction
    function automatic logic [31:0] o_stc(input int k);   return 32'(k == 0 ? stc0 : stc1);     endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input int k, input logic r, input logic w, input logic [2:0] sz,
                         input logic [31:0] a, input logic [31:0] d);
        req[k]  = r;
        we[k]   = w;
        size[k] = sz;
        addr[k] = a;
        wd[k]   = d;
    endtask

    task automatic do_idle(input int k);
        @(negedge clk);
        drive(k, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        #2;
    endtask

    task automatic do_store(input int k, input logic [2:0] sz, input logic [31:0] a,
                            input logic [31:0] d, input string tag);
        @(negedge clk);
        drive(k, 1'b1, 1'b1, sz, a, d);
        #2;
        check({tag, ":we"}, o_mwe(k), 32'd1);
        check({tag, ":stall"}, o_stall(k), 32'd0);
        check({tag, ":wd"}, o_mwd(k), d);
    endtask

    task automatic do_load(input int k, input logic [2:0] sz, input logic [31:0] a,
                           input logic [31:0] exp_rd, input int exp_stall, input string tag);
        int n;
        n = 0;
        @(negedge clk);
        drive(k, 1'b1, 1'b0, sz, a, 32'hFFFF_FFFF);
        #2;
        check({tag, ":adr"}, o_madr(k), a);
        check({tag, ":wd0"}, o_mwd(k), 32'd0);
        while (o_stall(k) == 32'd1 && n < 8) begin
            n++;
            @(negedge clk);
            #2;
        end
        check({tag, ":stall_cycles"}, 32'(n), 32'(exp_stall));
        check({tag, ":rd"}, o_rd(k), exp_rd);
    endtask

    task automatic do_fault(input int k, input logic w, input logic [2:0] sz, input logic [31:0] a,
                            input logic [1:0] exp_flt, input string tag);
        @(negedge clk);
        drive(k, 1'b1, w, sz, a, 32'h5555_5555);
        #2;
        check({tag, ":fault"}, o_flt(k), 32'(exp_flt));
        check({tag, ":stall"}, o_stall(k), 32'd0);
        check({tag, ":we"}, o_mwe(k), 32'd0);
        check({tag, ":wd"}, o_mwd(k), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        drive(0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        drive(1, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        repeat (2) @(negedge clk);
        #2;
        check("rst:stall", o_stall(0), 32'd0);
        check("rst:rd", o_rd(0), 32'd0);
        check("rst:fault", o_flt(0), 32'd0);
        check("rst:we", o_mwe(0), 32'd0);
        check("rst:adr", o_madr(0), 32'd0);
        check("rst:ldc", o_ldc(0), 32'd0);
        check("rst:stc", o_stc(0), 32'd0);
        check("rst:stall3", o_stall(1), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Word store then load back, single-cycle stall.
        do_store(0, SZ_W, 32'h10, 32'hDEAD_BEEF, "sw");
        check("sw:adr", o_madr(0), 32'h10);
        do_load(0, SZ_W, 32'h10, 32'hDEAD_BEEF, 1, "lw");
        do_idle(0);
        check("t1:rd_hold", o_rd(0), 32'hDEAD_BEEF);
        check("t1:ldc", o_ldc(0), 32'd1);
        check("t1:stc", o_stc(0), 32'd1);

        // Sub-word stores and sign/zero extension, back-to-back loads.
        do_store(0, SZ_B, 32'h13, 32'h0000_0080, "sb");
        do_load(0, SZ_B,  32'h13, 32'hFFFF_FF80, 1, "lb");
        do_load(0, SZ_BU, 32'h13, 32'h0000_0080, 1, "lbu");
        do_load(0, SZ_H,  32'h12, 32'hFFFF_80AD, 1, "lh");
        do_load(0, SZ_HU, 32'h11, 32'h0000_ADBE, 1, "lhu_off1");
        do_store(0, SZ_W, 32'hFC, 32'h7F11_2233, "sw_top");
        do_load(0, SZ_W,  32'hFC, 32'h7F11_2233, 1, "lw_top");
        do_load(0, SZ_B,  32'hFF, 32'h0000_007F, 1, "lb_last");
        do_idle(0);
        check("t2:ldc", o_ldc(0), 32'd7);
        check("t2:stc", o_stc(0), 32'd3);

        // Faults and their priority.
        do_fault(0, 1'b0, SZ_H,  32'h03,  FLT_MISAL, "lh_mis");
        do_fault(0, 1'b0, SZ_W,  32'h102, FLT_RANGE, "lw_range");
        do_fault(0, 1'b1, SZ_BU, 32'h10,  FLT_ILLSZ, "st_sz4");
        do_fault(0, 1'b0, 3'd3,  32'h200, FLT_ILLSZ, "ld_sz3");
        do_fault(0, 1'b0, SZ_W,  32'hFE,  FLT_MISAL, "lw_mis");
        do_fault(0, 1'b0, SZ_B,  32'h100, FLT_RANGE, "lb_range");
        do_fault(0, 1'b1, SZ_H,  32'h23,  FLT_MISAL, "sh_mis");
        do_idle(0);
        check("t3:fault_clr", o_flt(0), 32'd0);
        check("t3:ldc", o_ldc(0), 32'd7);
        check("t3:stc", o_stc(0), 32'd3);

        // Three-cycle latency, request activity during WAIT ignored.
        do_store(1, SZ_W, 32'h20, 32'hCAFE_F00D, "sw3");
        @(negedge clk);
        drive(1, 1'b1, 1'b0, SZ_W, 32'h20, 32'd0);
        #2;
        check("l3:c0_stall", o_stall(1), 32'd1);
        @(negedge clk);
        drive(1, 1'b1, 1'b1, SZ_W, 32'h40, 32'h1111_1111);
        #2;
        check("l3:c1_stall", o_stall(1), 32'd1);
        check("l3:c1_we", o_mwe(1), 32'd0);
        check("l3:c1_adr", o_madr(1), 32'h20);
        check("l3:c1_rd", o_rd(1), 32'd0);
        @(negedge clk);
        drive(1, 1'b0, 1'b0, SZ_B, 32'h44, 32'd0);
        #2;
        check("l3:c2_stall", o_stall(1), 32'd1);
        check("l3:c2_adr", o_madr(1), 32'h20);
        @(negedge clk);
        drive(1, 1'b1, 1'b1, SZ_W, 32'h40, 32'h1111_1111);
        #2;
        check("l3:c3_stall", o_stall(1), 32'd0);
        check("l3:c3_rd", o_rd(1), 32'hCAFE_F00D);
        check("l3:c3_we", o_mwe(1), 32'd0);
        do_idle(1);
        check("l3:rd_hold", o_rd(1), 32'hCAFE_F00D);
        check("l3:ldc", o_ldc(1), 32'd1);
        check("l3:stc", o_stc(1), 32'd1);

        // Reset in the middle of WAIT aborts the load.
        @(negedge clk);
        drive(1, 1'b1, 1'b0, SZ_W, 32'h20, 32'd0);
        #2;
        check("rw:c0_stall", o_stall(1), 32'd1);
        @(negedge clk);
        #2;
        check("rw:c1_stall", o_stall(1), 32'd1);
        rst_n = 1'b0;
        drive(1, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        #1;
        check("rw:stall", o_stall(1), 32'd0);
        check("rw:rd", o_rd(1), 32'd0);
        check("rw:adr", o_madr(1), 32'd0);
        check("rw:ldc", o_ldc(1), 32'd0);
        check("rw:ldc_lat1", o_ldc(0), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        do_load(1, SZ_W, 32'h20, 32'hCAFE_F00D, 3, "rw_lw");
        do_idle(1);
        check("rw:ldc_after", o_ldc(1), 32'd1);

        // Load counter saturation.
        @(negedge clk);
        force u_dut_lat1.ld_cnt_q = 16'hFFFE;
        #1;
        release u_dut_lat1.ld_cnt_q;
        #1;
        check("sat:preset", o_ldc(0), 32'h0000_FFFE);
        do_load(0, SZ_B, 32'hFF, 32'h0000_007F, 1, "sat1");
        do_idle(0);
        check("sat:after1", o_ldc(0), 32'h0000_FFFF);
        do_load(0, SZ_B, 32'hFF, 32'h0000_007F, 1, "sat2");
        do_load(0, SZ_B, 32'hFF, 32'h0000_007F, 1, "sat3");
        do_idle(0);
        check("sat:final", o_ldc(0), 32'h0000_FFFF);
        check("sat:stc", o_stc(0), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
